// File: rtl/trigger_timestamp_fifo_if.sv
// Readout link between one data source and the round-robin arbiter.
// The source (master) offers FIFO_DATA whenever FIFO_EMPTY is low (first-word-fall-through).
interface trigger_timestamp_fifo_if;
  // Handshake: FIFO_EMPTY=0 is "valid" and FIFO_READ is the "ready"/grant. A word
  // transfers on a rising CLK edge where FIFO_EMPTY=0 and FIFO_READ=1. FIFO_READ
  // while FIFO_EMPTY=1 is ignored. FIFO_PREEMPT_REQ=1 asks the arbiter to keep
  // granting this source until the pending second word of a record has transferred.
  logic        FIFO_READ;
  logic        FIFO_EMPTY;
  logic [31:0] FIFO_DATA;
  logic        FIFO_PREEMPT_REQ;

  modport master (
    input  FIFO_READ,
    output FIFO_EMPTY,
    output FIFO_DATA,
    output FIFO_PREEMPT_REQ
  );

  modport slave (
    output FIFO_READ,
    input  FIFO_EMPTY,
    input  FIFO_DATA,
    input  FIFO_PREEMPT_REQ
  );
endinterface

// File: rtl/trigger_timestamp_fifo.sv
// Trigger recorder: each enabled TRIGGER rising edge becomes a two-word record
// (sequence number, timestamp) buffered in a FIFO and read out word by word.
module trigger_timestamp_fifo #(
  parameter int          DEPTH           = 16,
  parameter logic [3:0]  DATA_IDENTIFIER = 4'b0110,
  parameter logic [23:0] TRIG_CNT_RESET  = 24'd0
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ENABLE,
  input  logic                      TRIGGER,
  input  logic [31:0]               TIMESTAMP,
  trigger_timestamp_fifo_if.master  bus,
  output logic                      FULL,
  output logic [23:0]               TRIG_CNT,
  output logic [7:0]                LOST_CNT,
  output logic                      dbg_phase
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic {
    PH_A = 1'b0,
    PH_B = 1'b1
  } phase_e;

  phase_e          phase_q, phase_d;
  logic            trig_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [50:0]     mem [DEPTH];
  logic [50:0]     head;
  logic            empty_q, empty_d;
  logic            full_q, full_d;
  logic            preempt_q, preempt_d;
  logic            event_w, wr_en, advance, pop_en;
  logic            unused_ts_bits;

  // Only the low 27 timestamp bits fit into word B.
  assign unused_ts_bits = ^TIMESTAMP[31:27];

  assign event_w = TRIGGER & ~trig_d & ENABLE;
  // Drop decision uses the count before any same-cycle pop.
  assign wr_en   = event_w & (count_q != CW'(DEPTH));
  assign advance = bus.FIFO_READ & (count_q != '0);
  assign pop_en  = advance & (phase_q == PH_B);

  // Next-state and registered-output logic of the read phase FSM.
  always_comb begin
    phase_d   = phase_q;
    count_d   = count_q;
    if (advance) begin
      phase_d = (phase_q == PH_A) ? PH_B : PH_A;
    end
    case ({wr_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    preempt_d = (phase_d == PH_B);
    empty_d   = (count_d == '0);
    full_d    = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      phase_q   <= PH_A;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      trig_d    <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      preempt_q <= 1'b0;
      TRIG_CNT  <= TRIG_CNT_RESET;
      LOST_CNT  <= 8'd0;
    end else begin
      phase_q   <= phase_d;
      count_q   <= count_d;
      trig_d    <= TRIGGER;
      empty_q   <= empty_d;
      full_q    <= full_d;
      preempt_q <= preempt_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (event_w) begin
        TRIG_CNT <= TRIG_CNT + 24'd1;
      end
      if (event_w && !wr_en && (LOST_CNT != 8'hFF)) begin
        LOST_CNT <= LOST_CNT + 8'd1;
      end
    end
  end

  // Record storage: {trig_no[23:0], ts[26:0]}, asynchronous read for fall-through.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_ptr_q] <= {TRIG_CNT, TIMESTAMP[26:0]};
    end
  end

  assign head = mem[rd_ptr_q];

  assign bus.FIFO_DATA = (phase_q == PH_B)
                       ? {DATA_IDENTIFIER, 1'b1, head[26:0]}
                       : {DATA_IDENTIFIER, 1'b0, 3'b000, head[50:27]};
  assign bus.FIFO_EMPTY       = empty_q;
  assign bus.FIFO_PREEMPT_REQ = preempt_q;
  assign FULL                 = full_q;
  assign dbg_phase            = phase_q;

endmodule

// File: tb/tb_trigger_timestamp_fifo.sv
// Bench for trigger_timestamp_fifo: queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_trigger_timestamp_fifo;
  localparam int DEPTH = 16;

  logic        CLK;
  logic        RST;
  logic        ENABLE;
  logic        TRIGGER;
  logic        trig2;
  logic [31:0] TIMESTAMP;
  logic        full_m, full_w;
  logic [23:0] trig_cnt_m, trig_cnt_w;
  logic [7:0]  lost_cnt_m, lost_cnt_w;
  logic        dbg_m, dbg_w;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 0;

  trigger_timestamp_fifo_if bm ();
  trigger_timestamp_fifo_if bw ();

  trigger_timestamp_fifo #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .TRIGGER(TRIGGER), .TIMESTAMP(TIMESTAMP),
    .bus(bm), .FULL(full_m), .TRIG_CNT(trig_cnt_m), .LOST_CNT(lost_cnt_m), .dbg_phase(dbg_m)
  );

  // Second instance starts its sequence counter at the wrap point.
  trigger_timestamp_fifo #(.DEPTH(4), .TRIG_CNT_RESET(24'hFFFFFF)) dut_wrap (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .TRIGGER(trig2), .TIMESTAMP(TIMESTAMP),
    .bus(bw), .FULL(full_w), .TRIG_CNT(trig_cnt_w), .LOST_CNT(lost_cnt_w), .dbg_phase(dbg_w)
  );

  // ---------------- clock ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- scoreboard / model ----------------
  logic [50:0] exp_q[$];
  bit          m_b;
  logic [23:0] m_trig;
  logic [7:0]  m_lost;
  logic        m_prev;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    int sz;
    sz = exp_q.size();
    if (RST) begin
      exp_q.delete();
      m_b    = 0;
      m_trig = '0;
      m_lost = '0;
    end else begin
      if (TRIGGER && !m_prev && ENABLE) begin
        if (sz < DEPTH) exp_q.push_back({m_trig, TIMESTAMP[26:0]});
        else if (m_lost != 8'hFF) m_lost = m_lost + 8'd1;
        m_trig = m_trig + 24'd1;
      end
      if (bm.FIFO_READ && sz > 0) begin
        if (m_b) begin
          void'(exp_q.pop_front());
          m_b = 0;
        end else begin
          m_b = 1;
        end
      end
    end
    m_prev = RST ? 1'b0 : TRIGGER;
  end

  always @(negedge CLK) begin
    logic [50:0] h;
    if (chk_en) begin
      chk("m_empty",   {31'd0, bm.FIFO_EMPTY},       {31'd0, exp_q.size() == 0});
      chk("m_preempt", {31'd0, bm.FIFO_PREEMPT_REQ}, {31'd0, m_b});
      chk("m_full",    {31'd0, full_m},              {31'd0, exp_q.size() == DEPTH});
      chk("m_trig",    {8'd0, trig_cnt_m},           {8'd0, m_trig});
      chk("m_lost",    {24'd0, lost_cnt_m},          {24'd0, m_lost});
      if (exp_q.size() > 0) begin
        h = exp_q[0];
        chk("m_data", bm.FIFO_DATA,
            m_b ? {4'h6, 1'b1, h[26:0]} : {4'h6, 4'h0, h[50:27]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(1);
    RST = 1'b0;
  endtask

  task automatic pulse(input logic [31:0] ts);
    TIMESTAMP = ts;
    TRIGGER   = 1'b1;
    step(1);
    TRIGGER   = 1'b0;
    step(1);
  endtask

  task automatic rd1();
    bm.FIFO_READ = 1'b1;
    step(1);
    bm.FIFO_READ = 1'b0;
  endtask

  task automatic drain(output int words);
    words = 0;
    for (int i = 0; i < 200 && bm.FIFO_EMPTY == 1'b0; i++) begin
      bm.FIFO_READ = 1'b1;
      step(1);
      words++;
    end
    bm.FIFO_READ = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int words;
    RST = 1'b1; ENABLE = 1'b0; TRIGGER = 1'b0; trig2 = 1'b0; TIMESTAMP = '0;
    bm.FIFO_READ = 1'b0; bw.FIFO_READ = 1'b0;
    step(2);
    chk_en = 1;
    RST = 1'b0;
    step(1);
    chk("rst_empty",   {31'd0, bm.FIFO_EMPTY},       32'd1);
    chk("rst_preempt", {31'd0, bm.FIFO_PREEMPT_REQ}, 32'd0);
    chk("rst_full",    {31'd0, full_m},              32'd0);
    chk("rst_trig",    {8'd0, trig_cnt_m},           32'd0);
    chk("rst_lost",    {24'd0, lost_cnt_m},          32'd0);

    // single record readout
    ENABLE = 1'b1; TIMESTAMP = 32'h0ABCDEF1; TRIGGER = 1'b1;
    step(1);
    TRIGGER = 1'b0;
    chk("t1_empty", {31'd0, bm.FIFO_EMPTY}, 32'd0);
    chk("t1_wordA", bm.FIFO_DATA, 32'h60000000);
    rd1();
    chk("t1_wordB",   bm.FIFO_DATA, 32'h6ABCDEF1);
    chk("t1_preempt", {31'd0, bm.FIFO_PREEMPT_REQ}, 32'd1);
    chk("t1_dbg",     {31'd0, dbg_m}, 32'd1);
    rd1();
    chk("t1_empty2",   {31'd0, bm.FIFO_EMPTY}, 32'd1);
    chk("t1_preempt2", {31'd0, bm.FIFO_PREEMPT_REQ}, 32'd0);

    // held-high trigger then disabled pulses
    do_reset();
    ENABLE = 1'b1; TRIGGER = 1'b1; TIMESTAMP = 32'h00000123;
    step(10);
    TRIGGER = 1'b0;
    step(1);
    ENABLE = 1'b0;
    for (int i = 0; i < 3; i++) pulse(32'h00000200 + i);
    chk("held_trig", {8'd0, trig_cnt_m}, 32'd1);
    drain(words);
    chk("held_words", words, 32'd2);

    // overflow: 20 triggers into 16 slots
    do_reset();
    ENABLE = 1'b1;
    for (int i = 0; i < 20; i++) pulse(32'h10000000 + i * 32'h00123457);
    chk("ovf_full", {31'd0, full_m}, 32'd1);
    chk("ovf_lost", {24'd0, lost_cnt_m}, 32'd4);
    chk("ovf_trig", {8'd0, trig_cnt_m}, 32'd20);
    for (int i = 0; i < 16; i++) begin
      chk("ovf_seq", bm.FIFO_DATA, 32'h60000000 | i);
      rd1();
      rd1();
    end
    chk("ovf_empty", {31'd0, bm.FIFO_EMPTY}, 32'd1);

    // event coincident with word-B pop while full
    do_reset();
    for (int i = 0; i < 16; i++) pulse(32'h00000040 + i);
    chk("co_full", {31'd0, full_m}, 32'd1);
    rd1();
    bm.FIFO_READ = 1'b1; TRIGGER = 1'b1;
    step(1);
    bm.FIFO_READ = 1'b0; TRIGGER = 1'b0;
    chk("co_lost", {24'd0, lost_cnt_m}, 32'd1);
    chk("co_full2", {31'd0, full_m}, 32'd0);
    chk("co_trig", {8'd0, trig_cnt_m}, 32'd17);
    chk("co_next", bm.FIFO_DATA, 32'h60000001);
    drain(words);
    chk("co_words", words, 32'd30);

    // LOST_CNT saturation
    do_reset();
    for (int i = 0; i < DEPTH + 260; i++) pulse(i);
    chk("sat_lost", {24'd0, lost_cnt_m}, 32'd255);
    chk("sat_trig", {8'd0, trig_cnt_m}, 32'd276);

    // reset in the middle of a record
    do_reset();
    pulse(32'h00000777);
    rd1();
    chk("rb_preempt", {31'd0, bm.FIFO_PREEMPT_REQ}, 32'd1);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    chk("rb_empty",   {31'd0, bm.FIFO_EMPTY}, 32'd1);
    chk("rb_preempt2",{31'd0, bm.FIFO_PREEMPT_REQ}, 32'd0);
    chk("rb_trig",    {8'd0, trig_cnt_m}, 32'd0);
    chk("rb_lost",    {24'd0, lost_cnt_m}, 32'd0);
    bm.FIFO_READ = 1'b1;
    step(3);
    bm.FIFO_READ = 1'b0;
    chk("rb_rd_empty",   {31'd0, bm.FIFO_EMPTY}, 32'd1);
    chk("rb_rd_preempt", {31'd0, bm.FIFO_PREEMPT_REQ}, 32'd0);

    // sequence-number wrap on the fast-forwarded instance
    do_reset();
    ENABLE = 1'b1;
    TIMESTAMP = 32'hFFFFFFFF; trig2 = 1'b1; step(1); trig2 = 1'b0; step(1);
    TIMESTAMP = 32'h00000005; trig2 = 1'b1; step(1); trig2 = 1'b0; step(1);
    chk("wrap_wordA", bw.FIFO_DATA, 32'h60FFFFFF);
    chk("wrap_trig",  {8'd0, trig_cnt_w}, 32'd1);
    bw.FIFO_READ = 1'b1; step(1); bw.FIFO_READ = 1'b0;
    chk("wrap_wordB", bw.FIFO_DATA, 32'h6FFFFFFF);
    bw.FIFO_READ = 1'b1; step(1); bw.FIFO_READ = 1'b0;
    chk("wrap_next",  bw.FIFO_DATA, 32'h60000000);
    bw.FIFO_READ = 1'b1; step(1); bw.FIFO_READ = 1'b0;
    chk("wrap_nextB", bw.FIFO_DATA, 32'h68000005);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
